// File: rtl/arp_pkg.sv
// ARP field constants, frame offsets and responder state encoding.
// Build option ARP_PAD_EN pads the reply to the 60-byte Ethernet minimum.
package arp_pkg;
    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN_ETH      = 8'h06;
    localparam logic [7:0]  PLEN_IPV4     = 8'h04;
    localparam logic [15:0] OPER_REQUEST  = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;

    localparam logic [5:0] OFF_SRC   = 6'd6;
    localparam logic [5:0] OFF_ETYPE = 6'd12;
    localparam logic [5:0] OFF_SHA   = 6'd22;
    localparam logic [5:0] OFF_SPA   = 6'd28;
    localparam logic [5:0] OFF_TPA   = 6'd38;
    localparam logic [5:0] ARP_LEN   = 6'd42;
    localparam logic [5:0] IDX_MAX   = 6'd63;

`ifdef ARP_PAD_EN
    localparam logic [5:0] REPLY_LEN = 6'd60;
`else
    localparam logic [5:0] REPLY_LEN = 6'd42;
`endif

    typedef enum logic {
        ST_RX = 1'b0,
        ST_TX = 1'b1
    } state_e;
endpackage

// File: rtl/arp_tx_gen.sv
// Purpose: ARP reply byte sequencer (byte counter + field mux); pads with zeros under ARP_PAD_EN.
// Latency: first byte valid in the same cycle active rises (active is a registered state bit).
// Backpressure: counter advances only on tx_valid && tx_ready; outputs hold while stalled.
module arp_tx_gen
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_010A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        active,
    input  logic [47:0] sha,
    input  logic [31:0] spa,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last
);
    logic [5:0]             cnt_q;
    logic                   at_end;
    logic [ARP_LEN*8-1:0]   reply_vec;
    logic [ARP_LEN*8-1:0]   reply_sh;

    assign at_end = (cnt_q == REPLY_LEN - 6'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 6'd0;
        end else if (!active) begin
            cnt_q <= 6'd0;
        end else if (tx_ready) begin
            cnt_q <= at_end ? 6'd0 : cnt_q + 6'd1;
        end
    end

    // Whole ARP reply as one vector; shifting by the byte count brings the current byte to the top.
    always_comb begin
        reply_vec = {sha, LOCAL_MAC, ETHERTYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN_ETH, PLEN_IPV4,
                     OPER_REPLY, LOCAL_MAC, LOCAL_IP, sha, spa};
        reply_sh  = reply_vec << {cnt_q, 3'b000};
        tx_valid  = active;
        tx_last   = active && at_end;
        tx_data   = 8'h00;
        if (active && (cnt_q < ARP_LEN)) begin
            tx_data = reply_sh[ARP_LEN*8-1 -: 8];
        end
    end
endmodule

// File: rtl/arp_responder.sv
// Purpose: ARP request parser and reply engine for LOCAL_MAC/LOCAL_IP; ARP_PAD_EN pads reply to 60 bytes.
// Latency: reply tx_valid rises one cycle after the accepted rx_last.
// Backpressure: none on rx (bytes arriving during a reply are dropped); tx uses valid/ready.
module arp_responder
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_010A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_error,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic [15:0] req_count
);
    state_e      state_q, state_d;
    logic [5:0]  idx_q;
    logic        bad_q, bc_ok_q, lm_ok_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q;

    logic        rx_take, accept, byte_bad, chk, is_dst;
    logic        bc_ok_d, lm_ok_d;
    logic [7:0]  exp_byte;
    logic [79:0] hdr_sh;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;

    assign rx_take = rx_valid && (state_q == ST_RX);

    // Per-byte header check against the expected request fields.
    always_comb begin
        hdr_sh   = {ETHERTYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN_ETH, PLEN_IPV4, OPER_REQUEST}
                   << {idx_q - OFF_ETYPE, 3'b000};
        mac_sh   = LOCAL_MAC << {idx_q, 3'b000};
        ip_sh    = LOCAL_IP << {idx_q - OFF_TPA, 3'b000};
        chk      = 1'b0;
        exp_byte = 8'h00;
        if ((idx_q >= OFF_ETYPE) && (idx_q < OFF_SHA)) begin
            chk      = 1'b1;
            exp_byte = hdr_sh[79:72];
        end else if ((idx_q >= OFF_TPA) && (idx_q < ARP_LEN)) begin
            chk      = 1'b1;
            exp_byte = ip_sh[31:24];
        end
        is_dst   = (idx_q < OFF_SRC);
        byte_bad = rx_error || (chk && (rx_data != exp_byte));
        bc_ok_d  = bc_ok_q && (!is_dst || (rx_data == 8'hFF));
        lm_ok_d  = lm_ok_q && (!is_dst || (rx_data == mac_sh[47:40]));
        accept   = rx_take && rx_last && !bad_q && !byte_bad && (bc_ok_q || lm_ok_q)
                   && (idx_q >= ARP_LEN - 6'd1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RX: if (accept) state_d = ST_TX;
            ST_TX: if (tx_valid && tx_ready && tx_last) state_d = ST_RX;
            default: state_d = ST_RX;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RX;
        end else begin
            state_q <= state_d;
        end
    end

    // Every rx_last in RX closes the frame, so the index is already 0 while a reply runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= 6'd0;
            bad_q     <= 1'b0;
            bc_ok_q   <= 1'b1;
            lm_ok_q   <= 1'b1;
            sha_q     <= 48'h0;
            spa_q     <= 32'h0;
            req_count <= 16'h0;
        end else begin
            if (rx_take) begin
                if (rx_last) begin
                    idx_q   <= 6'd0;
                    bad_q   <= 1'b0;
                    bc_ok_q <= 1'b1;
                    lm_ok_q <= 1'b1;
                end else begin
                    idx_q   <= (idx_q == IDX_MAX) ? idx_q : idx_q + 6'd1;
                    bad_q   <= bad_q || byte_bad;
                    bc_ok_q <= bc_ok_d;
                    lm_ok_q <= lm_ok_d;
                end
                if ((idx_q >= OFF_SHA) && (idx_q < OFF_SPA)) begin
                    sha_q <= {sha_q[39:0], rx_data};
                end
                if ((idx_q >= OFF_SPA) && (idx_q < OFF_SPA + 6'd4)) begin
                    spa_q <= {spa_q[23:0], rx_data};
                end
            end
            if (accept) begin
                req_count <= req_count + 16'd1;
            end
        end
    end

    arp_tx_gen #(
        .LOCAL_MAC (LOCAL_MAC),
        .LOCAL_IP  (LOCAL_IP)
    ) u_tx_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .active   (state_q == ST_TX),
        .sha      (sha_q),
        .spa      (spa_q),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last)
    );
endmodule
